// File: rtl/display_ctrl_if.sv
// display_ctrl_if
//   Handshake and result bus between the datapath (master) and the
//   display controller (slave).
//   load    : request to convert value (master -> slave)
//   sign_en : 1 = value is two's complement, 0 = unsigned
//   value   : WIDTH-bit binary operand
//   ready   : slave idle and able to accept load
//   done    : one-cycle pulse, codes just updated
//   codes   : 4 bits per position, position 0 least significant
interface display_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                      load;
    logic                      sign_en;
    logic [WIDTH-1:0]          value;
    logic                      ready;
    logic                      done;
    logic [4*(DIGITS+1)-1:0]   codes;

    modport master (output load, sign_en, value, input  ready, done, codes);
    modport slave  (input  load, sign_en, value, output ready, done, codes);
endinterface

// File: rtl/display_controller.sv
// display_controller
//   Converts a binary value into per-position digit codes for active-low
//   7-segment decoders using a shift-and-add-3 (double-dabble) sequence,
//   then applies sign placement and publishes all codes in one edge.
//   Codes: 0-9 digit, 11 minus sign, 15 blank.
// Ports
//   clk_i : clock, all state on rising edge
//   rst_i : synchronous active-high reset
//   bus   : display_ctrl_if.slave (load/sign_en/value in; ready/done/codes out)
// Build option
//   DISPLAY_CTRL_LZB_EN : when defined, leading zeros are blanked and the
//   minus sign sits directly above the most significant nonzero digit.
//   When undefined, all digits are shown and the sign sits in the top position.
module display_controller #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    display_ctrl_if.slave  bus
);
    localparam int CW  = $clog2(WIDTH + 1);
    localparam int BW  = 4 * DIGITS;
    localparam int POS = DIGITS + 1;

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_FORMAT} state_e;

    state_e            state_q;
    logic [CW-1:0]     cnt_q;
    logic [WIDTH-1:0]  mag_q;
    logic [BW-1:0]     bcd_q;
    logic              neg_q;
    logic              done_q;
    logic [4*POS-1:0]  codes_q;

    logic [BW-1:0]     bcd_adj;
    logic [4*POS-1:0]  codes_d;
    logic              neg_in;

    assign neg_in = bus.sign_en & bus.value[WIDTH-1];

    // Add-3 correction on every nibble that would overflow past 9 after the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

`ifdef DISPLAY_CTRL_LZB_EN
    int msd;
    // msd = highest nonzero digit; zero value keeps msd at 0 so a single 0 shows.
    always_comb begin
        msd     = 0;
        codes_d = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] != 4'd0) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (i <= msd) codes_d[4*i +: 4] = bcd_q[4*i +: 4];
        end
        for (int i = 0; i < POS; i++) begin
            if (neg_q && (i == msd + 1)) codes_d[4*i +: 4] = 4'hB;
        end
    end
`else
    always_comb begin
        codes_d = '1;
        for (int i = 0; i < DIGITS; i++)
            codes_d[4*i +: 4] = bcd_q[4*i +: 4];
        codes_d[4*DIGITS +: 4] = neg_q ? 4'hB : 4'hF;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
            codes_q <= '1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.load) begin
                        neg_q   <= neg_in;
                        // -2^(WIDTH-1) wraps to itself, which is the correct magnitude.
                        mag_q   <= neg_in ? (~bus.value + 1'b1) : bus.value;
                        bcd_q   <= '0;
                        cnt_q   <= CW'(WIDTH);
                        state_q <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    bcd_q <= {bcd_adj[BW-2:0], mag_q[WIDTH-1]};
                    mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) state_q <= S_FORMAT;
                end
                S_FORMAT: begin
                    codes_q <= codes_d;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // ready is combinational so load can be re-accepted in the done cycle.
    assign bus.ready = (state_q == S_IDLE) && !rst_i;
    assign bus.done  = done_q;
    assign bus.codes = codes_q;
endmodule

// File: tb/tb_display_controller.sv
module tb_display_controller;
    localparam int W  = 8;
    localparam int D  = 3;
    localparam int CB = 4 * (D + 1);

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    display_ctrl_if #(.WIDTH(W), .DIGITS(D)) bus ();

    display_controller #(.WIDTH(W), .DIGITS(D)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed/unsigned magnitude by plain arithmetic, decimal digits by div/mod.
    function automatic logic [CB-1:0] model(input logic [W-1:0] v, input logic s);
        logic [CB-1:0] r;
        int m, top;
        int d [D];
        bit n;
        n = s && v[W-1];
        m = n ? ((1 << W) - int'(v)) : int'(v);
        for (int i = 0; i < D; i++) begin
            d[i] = m % 10;
            m    = m / 10;
        end
        r = '1;
`ifdef DISPLAY_CTRL_LZB_EN
        top = 0;
        for (int i = 0; i < D; i++) if (d[i] != 0) top = i;
        for (int i = 0; i <= top; i++) r[4*i +: 4] = 4'(d[i]);
        if (n) r[4*(top+1) +: 4] = 4'hB;
`else
        top = 0;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'(d[i]);
        r[4*D +: 4] = n ? 4'hB : 4'hF;
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full conversion with exact latency checks; inputs are scrambled after accept.
    task automatic run_conv(input logic [W-1:0] v, input logic s, input string tag);
        logic [CB-1:0] exp;
        exp = model(v, s);
        check({tag, "_ready_pre"}, 32'(bus.ready), 1);
        bus.load = 1'b1; bus.value = v; bus.sign_en = s;
        tick();
        bus.load = 1'b0; bus.value = W'($urandom); bus.sign_en = 1'($urandom);
        for (int k = 0; k <= W; k++) begin
            check({tag, "_done_mid"}, 32'(bus.done), 0);
            check({tag, "_ready_mid"}, 32'(bus.ready), 0);
            tick();
        end
        check({tag, "_done"}, 32'(bus.done), 1);
        check({tag, "_ready_done"}, 32'(bus.ready), 1);
        check({tag, "_codes"}, 32'(bus.codes), 32'(exp));
        tick();
        check({tag, "_done_1cyc"}, 32'(bus.done), 0);
        check({tag, "_codes_hold"}, 32'(bus.codes), 32'(exp));
    endtask

    initial begin
        int pulses, first, second;
        logic [W-1:0] rv;
        logic rs;
        rst = 1'b1;
        bus.load = 1'b0; bus.value = '0; bus.sign_en = 1'b0;

        // Reset
        tick(); tick();
        check("rst_ready_low", 32'(bus.ready), 0);
        check("rst_codes", 32'(bus.codes), 32'hFFFF);
        check("rst_done", 32'(bus.done), 0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 32'(bus.ready), 1);
        check("post_rst_codes", 32'(bus.codes), 32'hFFFF);

        // Directed values
        run_conv(8'h00, 1'b1, "zero");
        run_conv(8'h80, 1'b1, "min_neg");
        run_conv(8'hF9, 1'b1, "neg7");
        run_conv(8'hF9, 1'b0, "u249");
        run_conv(8'hFF, 1'b0, "u255");
        run_conv(8'h7F, 1'b1, "max_pos");
        run_conv(8'h0A, 1'b1, "ten");

        // Load while busy is ignored
        bus.load = 1'b1; bus.value = 8'h05; bus.sign_en = 1'b1;
        tick();
        pulses = 0;
        for (int k = 0; k <= W + 3; k++) begin
            if (k <= W) check("ign_ready", 32'(bus.ready), 0);
            if (bus.done) begin
                pulses++;
                check("ign_when", 32'(k), 32'(W + 1));
                check("ign_codes", 32'(bus.codes), 32'(model(8'h05, 1'b1)));
            end
            bus.load  = (k == 2);
            bus.value = (k == 2) ? 8'h63 : 8'h00;
            tick();
        end
        check("ign_pulses", 32'(pulses), 1);

        // Reset mid-conversion
        bus.load = 1'b1; bus.value = 8'h7F; bus.sign_en = 1'b1;
        tick();
        bus.load = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("midrst_codes", 32'(bus.codes), 32'hFFFF);
        check("midrst_ready", 32'(bus.ready), 0);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < W + 4; k++) begin
            if (bus.done) pulses++;
            tick();
        end
        check("midrst_no_done", 32'(pulses), 0);
        check("midrst_codes_hold", 32'(bus.codes), 32'hFFFF);
        run_conv(8'h2A, 1'b0, "after_rst");

        // Back-to-back with load held high
        bus.load = 1'b1; bus.value = 8'h01; bus.sign_en = 1'b0;
        tick();
        bus.value = 8'h02;
        first = -1; second = -1;
        for (int k = 0; k < 2 * W + 6; k++) begin
            if (bus.done) begin
                if (first < 0) begin
                    first = k;
                    check("b2b_codes1", 32'(bus.codes), 32'(model(8'h01, 1'b0)));
                    check("b2b_ready", 32'(bus.ready), 1);
                end else begin
                    second = k;
                    check("b2b_codes2", 32'(bus.codes), 32'(model(8'h02, 1'b0)));
                end
            end
            if (first >= 0 && k == first + 1) bus.load = 1'b0;
            tick();
        end
        check("b2b_first", 32'(first), 32'(W + 1));
        check("b2b_gap", 32'(second - first), 32'(W + 2));

        // Randomized
        for (int t = 0; t < 25; t++) begin
            rv = W'($urandom);
            rs = 1'($urandom);
            run_conv(rv, rs, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/display_controller.md
# display_controller

Sequential controller that converts a binary result from the processor datapath into per-position digit codes for a bank of active-low 7-segment decoders. It accepts one value per load/ready handshake, runs a shift-and-add-3 (double-dabble) conversion, applies sign placement and optional leading-zero blanking, then publishes all codes atomically. It sits between the register-file/ALU result bus and the board's digit decoders. Each decoder maps 0–9 to digits, 11 to a minus sign and any other code to blank.

## Interface
- WIDTH, 8: bit width of `value`.
- DIGITS, 3: number of magnitude digit positions. Total positions = DIGITS+1. Integrator must guarantee 10^DIGITS > 2^WIDTH − 1; there is no runtime check.

- Clock  in  1  sole clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- load  in  1  request to convert `value`; accepted only on an edge where `ready`=1.
- sign_en  in  1  sampled with `value`. 1 = two's-complement signed; 0 = unsigned.
- value  in  WIDTH  binary operand.
- ready  out  1  high when idle and able to accept `load`. Low while Reset=1.
- done  out  1  one-cycle pulse when `codes` has just been updated.
- codes  out  4*(DIGITS+1)  position i at bits [4i+3:4i]; position 0 is least significant.

## Operation
- States:
  - IDLE: `ready`=1. An edge with load=1 goes to CONVERT.
  - CONVERT: runs exactly WIDTH edges, then goes to FORMAT.
  - FORMAT: one edge, then goes to IDLE.
- Capture, on the accept edge:
  - neg = sign_en & value[WIDTH−1].
  - mag = neg ? −value : value, held as a WIDTH-bit unsigned value. −2^(WIDTH−1) therefore gives magnitude 2^(WIDTH−1).
  - BCD register cleared. Bit counter set to WIDTH.
- Each CONVERT edge: every BCD nibble ≥5 gets +3. Then {bcd, mag} shifts left by one. Counter decrements.
- FORMAT edge: `codes` is loaded from the BCD nibbles plus the sign/blank rules below, and `done` is set for one cycle.
- `codes` holds its value between conversions; it changes only on a FORMAT edge or on reset.
- `load` while `ready`=0 is ignored. It is not queued.
- `value` and `sign_en` are sampled only on the accept edge. Later changes have no effect.

## Timing
- Reset values: codes = all positions 4'hF, done = 0. State is IDLE, so `ready`=1 in the first cycle after Reset deasserts.
- Reset mid-conversion: the operation is abandoned, no `done` pulse is produced, and `codes` are forced to all-blank.
- Latency: accept at edge N. FORMAT executes at edge N+WIDTH+1. `done`=1, `ready`=1 and the new `codes` are all visible in the cycle that follows that edge.
- Back-to-back: `load` held high re-accepts in the same cycle `done` is high. Minimum throughput is one conversion every WIDTH+2 cycles.
- `done` never lasts more than one cycle.

## Configuration
- DISPLAY_CTRL_LZB_EN defined (leading-zero blanking):
  - Magnitude positions above the most significant nonzero digit are code 15.
  - Value 0 shows a single 0 at position 0.
  - If neg, code 11 goes in the position immediately above the most significant nonzero digit. All higher positions are 15.
- DISPLAY_CTRL_LZB_EN undefined:
  - All DIGITS magnitude positions show their digit, including leading zeros.
  - Position DIGITS holds 11 if neg, otherwise 15.
- Latency is identical in both builds.

## Test plan
All scenarios use WIDTH=8, DIGITS=3, LZB_EN defined unless noted. Codes are listed pos3..pos0.
- Reset → codes=F,F,F,F, done=0, ready=1 the cycle after release. Reset held high → ready=0.
- load value=0x00, sign_en=1 → `done` in the cycle after the 9th edge following accept; codes=F,F,F,0. Value 0x80, sign_en=1 → B,1,2,8.
- Value 0xF9: sign_en=1 → F,F,B,7. sign_en=0 (249) → F,2,4,9. Build without macro, sign_en=1 → B,0,0,7.
- Accept value 0x05. At edge 3, load value 0x63 → ignored, ready=0 throughout. Result codes=F,F,F,5. Exactly one `done` pulse.
- Accept 0x7F. Reset at edge 4 → no `done` pulse, codes=F,F,F,F. Next load 0x2A → F,F,4,2.
- load held high with values 0x01 then 0x02 → two `done` pulses WIDTH+2 cycles apart, codes F,F,F,1 then F,F,F,2.
